jtcontra_sdram_arb: RTL and testbench
=====================================

JTCONTRA_SDRAM_ARB -- requirements
Module: jtcontra_sdram_arb

Interface
REQ-001 SHALL have parameter SLOT0_OFFSET, default 22'h0, word offset added to slot 0 (GFX1) address.
REQ-002 SHALL have parameters SLOT1_OFFSET, SLOT2_OFFSET and SLOT3_OFFSET, default 22'h0 each, the same offset for slots 1 (GFX2), 2 (sound) and 3 (main).
REQ-003 SHALL have ports: clk in 1, sole clock; rst_n in 1, reset that is asynchronous and active-low.
REQ-004 SHALL have ports: vblank in 1, high during vertical blank; downloading in 1, ROM load in progress; loop_rst in 1, frame-level flush.
REQ-005 SHALL have ports per slot i=0..3: slot<i>_cs in 1, request; slot<i>_addr in 22, word address before offset; slot<i>_ok out 1, data valid for the current addr; slot<i>_dout out 32, cached read data.
REQ-006 SHALL have ports: sdram_req out 1; sdram_addr out 22; sdram_ack in 1; data_rdy in 1; data_read in 32; refresh_en out 1.

Function
REQ-007 Each slot SHALL hold a tag (22 b), a data word (32 b) and a valid bit.
REQ-008 A slot SHALL be a hit when cs=1, valid=1 and addr==tag; on a hit, slot<i>_ok SHALL be registered high on the next clk.
REQ-009 slot<i>_ok SHALL drop on the clk following any cycle with cs=0 or addr!=tag.
REQ-010 A slot SHALL be pending when cs=1 and it is not a hit.
REQ-011 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-012 In IDLE with any slot pending, the FSM SHALL latch the winning slot and the latched address, then enter REQ.
REQ-013 In REQ, sdram_req SHALL be 1 and sdram_addr SHALL be the latched address plus the slot offset, mod 2^22; on sdram_ack the FSM SHALL enter WAIT and sdram_req SHALL fall.
REQ-014 In WAIT, on data_rdy the arbiter SHALL write data_read and the latched address into the winner's data and tag, set valid, and return to IDLE.
REQ-015 Fixed priority SHALL be slot3 > slot2 > slot0 > slot1.
REQ-016 If cs falls or addr changes during REQ or WAIT, the transaction SHALL still complete and fill the cache against the latched address; ok SHALL follow REQ-008, and the new address SHALL re-arbitrate.
REQ-017 A pending slot that is the winner and arrives together with data_rdy SHALL NOT be granted until the FSM is back in IDLE, which adds one cycle.
REQ-018 refresh_en SHALL be 1 only in IDLE with no slot pending.
REQ-019 While downloading or loop_rst is 1, the arbiter SHALL force IDLE from any state, clear all valid bits, hold sdram_req=0, hold all ok=0 and hold refresh_en=0.
REQ-020 sdram_ack or data_rdy arriving in an unexpected state SHALL be ignored.

Reset
REQ-021 While rst_n=0, the arbiter SHALL hold the FSM in IDLE.
REQ-022 While rst_n=0, it SHALL drive sdram_req=0, sdram_addr=0 and refresh_en=0.
REQ-023 While rst_n=0, it SHALL hold all ok=0, all dout=0, all tags=0 and all valid=0.
REQ-024 Reset assertion mid-transaction SHALL abandon that transaction without filling the cache.

Configuration
REQ-025 With JTCONTRA_ARB_VBLANK_RR_EN defined, and only while vblank=1, the grant SHALL rotate round-robin starting after the last granted slot.
REQ-026 The round-robin pointer SHALL reset to slot3.
REQ-027 Without JTCONTRA_ARB_VBLANK_RR_EN, REQ-015 SHALL apply at all times and no pointer SHALL be built.

Structure
REQ-028 Package jtcontra_arb_pkg SHALL hold NSLOTS=4, slot index constants, the state enum and the fixed priority order.
REQ-029 Sub-module jtcontra_arb_slot SHALL implement one tag/data/valid entry, its hit compare and its registered ok; it SHALL be instantiated four times.

Verification
REQ-030 Cold miss: slot3 cs=1, addr=0x00100 with SLOT3_OFFSET=0 -> sdram_req=1 with sdram_addr=0x00100; ack, then data_rdy with data 0xDEADBEEF -> slot3_ok=1 one clk after IDLE, slot3_dout=0xDEADBEEF.
REQ-031 Hit: repeat the same slot3 addr -> ok=1 next clk with no sdram_req; change addr to 0x00101 -> ok=0 next clk, then a new fetch.
REQ-032 Priority: slots 0..3 request misses in the same cycle, vblank=0 -> grant order 3, 2, 0, 1; with the macro and vblank=1 the order after a last grant of 3 -> 0, 1, 2, 3.
REQ-033 Offset wrap: SLOT1_OFFSET=0x3FFFFF, addr=0x2 -> sdram_addr=0x000001.
REQ-034 Abort: downloading=1 in WAIT -> next clk IDLE, sdram_req=0, all ok=0; a later data_rdy does not fill the cache; after release the same addr misses.
REQ-035 Mid-flight change: slot2 addr changes while in WAIT -> the fill is stored for the old addr, ok stays 0, and the new addr is fetched.

Source files
------------

// File: rtl/jtcontra_arb_pkg.sv
// -----------------------------------------------------------------------------
// jtcontra_arb_pkg
// Shared constants for the Contra SDRAM cache arbiter: slot count and indices,
// FSM state encoding and the fixed grant priority order.
// -----------------------------------------------------------------------------
package jtcontra_arb_pkg;

    localparam int NSLOTS = 4;
    localparam int AW     = 22;
    localparam int DW     = 32;

    // Slot indices
    localparam logic [1:0] SLOT_GFX1 = 2'd0;
    localparam logic [1:0] SLOT_GFX2 = 2'd1;
    localparam logic [1:0] SLOT_SND  = 2'd2;
    localparam logic [1:0] SLOT_MAIN = 2'd3;

    // FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_REQ  = 2'd1;
    localparam arb_state_t ST_WAIT = 2'd2;

    // Fixed priority: rank 0 (highest) lives in the two LSBs.
    // Order main > sound > gfx1 > gfx2.
    localparam logic [7:0] PRIO_ORDER = {SLOT_GFX2, SLOT_GFX1, SLOT_SND, SLOT_MAIN};

    // Slot index holding the given priority rank (0 = highest)
    function automatic logic [1:0] prio_slot(input int rank);
        return PRIO_ORDER[rank*2 +: 2];
    endfunction

endpackage

// File: rtl/jtcontra_arb_slot.sv
// -----------------------------------------------------------------------------
// jtcontra_arb_slot
// One single-entry cache line: tag, data word and valid bit, the hit compare
// against the requester's current address, and the registered ok flag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous invalidate, also forces ok low
//   cs, addr            requester strobe and word address (before offset)
//   fill_en/addr/data   write a fresh line from SDRAM
//   hit                 combinational hit (cs & valid & tag match)
//   ok, dout            registered data-valid flag and cached data
// -----------------------------------------------------------------------------
module jtcontra_arb_slot
    import jtcontra_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] tag_r;
    logic [DW-1:0] data_r;
    logic          valid_r;
    logic          ok_r;

    assign hit  = cs & valid_r & (addr == tag_r);
    assign ok   = ok_r;
    assign dout = data_r;

    // Line storage and registered ok; flush wins over a concurrent fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r   <= {AW{1'b0}};
            data_r  <= {DW{1'b0}};
            valid_r <= 1'b0;
            ok_r    <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            ok_r    <= 1'b0;
        end else begin
            ok_r <= hit;
            if (fill_en) begin
                tag_r   <= fill_addr;
                data_r  <= fill_data;
                valid_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtcontra_sdram_arb.sv
// -----------------------------------------------------------------------------
// jtcontra_sdram_arb
// Four-slot SDRAM read arbiter with a one-word cache per slot. Misses are
// arbitrated (main > sound > gfx1 > gfx2), fetched through an IDLE/REQ/WAIT
// handshake and written into the winning slot against the address latched at
// grant time. downloading or loop_rst flush every slot and abort traffic.
// Optional build macro: JTCONTRA_ARB_VBLANK_RR_EN -- while vblank is high the
// grant rotates round-robin starting after the last granted slot.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   vblank, downloading, loop_rst    frame status / flush controls
//   slot<i>_cs/_addr/_ok/_dout       per-slot request and cached response
//   sdram_req/_addr/_ack             SDRAM request handshake
//   data_rdy, data_read              SDRAM read return
//   refresh_en                       SDRAM may refresh (idle, nothing pending)
// -----------------------------------------------------------------------------
module jtcontra_sdram_arb
    import jtcontra_arb_pkg::*;
#(
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        slot0_cs,
    input  logic [21:0] slot0_addr,
    output logic        slot0_ok,
    output logic [31:0] slot0_dout,
    input  logic        slot1_cs,
    input  logic [21:0] slot1_addr,
    output logic        slot1_ok,
    output logic [31:0] slot1_dout,
    input  logic        slot2_cs,
    input  logic [21:0] slot2_addr,
    output logic        slot2_ok,
    output logic [31:0] slot2_dout,
    input  logic        slot3_cs,
    input  logic [21:0] slot3_addr,
    output logic        slot3_ok,
    output logic [31:0] slot3_dout,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read,
    output logic        refresh_en
);

    logic [NSLOTS-1:0] cs_s;
    logic [AW-1:0]     addr_s [NSLOTS];
    logic [NSLOTS-1:0] hit_s;
    logic [NSLOTS-1:0] ok_s;
    logic [DW-1:0]     dout_s [NSLOTS];
    logic [NSLOTS-1:0] pending_s;
    logic              any_pending_s;
    logic              flush_s;
    logic              fill_s;
    logic [1:0]        sel_fix_s;
    logic [1:0]        sel_s;
    logic [AW-1:0]     off_s;
    logic [AW-1:0]     req_addr_s;

    arb_state_t        state_r;
    logic [1:0]        win_r;
    logic [AW-1:0]     lat_addr_r;
    logic              sdram_req_r;
    logic [AW-1:0]     sdram_addr_r;
    logic              run_r;

    assign cs_s      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr_s[0] = slot0_addr;
    assign addr_s[1] = slot1_addr;
    assign addr_s[2] = slot2_addr;
    assign addr_s[3] = slot3_addr;

    assign flush_s       = downloading | loop_rst;
    assign pending_s     = cs_s & ~hit_s;
    assign any_pending_s = |pending_s;
    assign fill_s        = (state_r == ST_WAIT) & data_rdy & ~flush_s;

    genvar g;
    generate
        for (g = 0; g < NSLOTS; g++) begin : g_slot
            jtcontra_arb_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush_s),
                .cs        (cs_s[g]),
                .addr      (addr_s[g]),
                .fill_en   (fill_s && (win_r == 2'(g))),
                .fill_addr (lat_addr_r),
                .fill_data (data_read),
                .hit       (hit_s[g]),
                .ok        (ok_s[g]),
                .dout      (dout_s[g])
            );
        end
    endgenerate

    assign slot0_ok   = ok_s[0];
    assign slot1_ok   = ok_s[1];
    assign slot2_ok   = ok_s[2];
    assign slot3_ok   = ok_s[3];
    assign slot0_dout = dout_s[0];
    assign slot1_dout = dout_s[1];
    assign slot2_dout = dout_s[2];
    assign slot3_dout = dout_s[3];

    // Fixed-priority pick: walk from lowest rank up so the highest rank wins
    always_comb begin
        sel_fix_s = SLOT_MAIN;
        for (int k = NSLOTS - 1; k >= 0; k--) begin
            sel_fix_s = pending_s[prio_slot(k)] ? prio_slot(k) : sel_fix_s;
        end
    end

`ifdef JTCONTRA_ARB_VBLANK_RR_EN
    logic [1:0] rr_ptr_r;
    logic [1:0] sel_rr_s;

    // Round-robin pick: ptr+1 is the first candidate, ptr itself is last
    always_comb begin
        logic [1:0] idx;
        sel_rr_s = rr_ptr_r;
        for (int k = NSLOTS; k >= 1; k--) begin
            idx      = rr_ptr_r + 2'(k);
            sel_rr_s = pending_s[idx] ? idx : sel_rr_s;
        end
    end

    assign sel_s = vblank ? sel_rr_s : sel_fix_s;

    // Pointer tracks every grant so rotation resumes after the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= SLOT_MAIN;
        end else if (!flush_s && (state_r == ST_IDLE) && any_pending_s) begin
            rr_ptr_r <= sel_s;
        end
    end
`else
    logic unused_vblank_s;
    assign unused_vblank_s = vblank;
    assign sel_s           = sel_fix_s;
`endif

    // Per-slot word offset of the current pick
    always_comb begin
        case (sel_s)
            SLOT_GFX1: off_s = SLOT0_OFFSET;
            SLOT_GFX2: off_s = SLOT1_OFFSET;
            SLOT_SND:  off_s = SLOT2_OFFSET;
            SLOT_MAIN: off_s = SLOT3_OFFSET;
            default:   off_s = 22'h0;
        endcase
    end

    // Sum wraps naturally at 22 bits
    assign req_addr_s = addr_s[sel_s] + off_s;

    // Request FSM: grant latches slot and raw address; offset is applied once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            win_r        <= 2'd0;
            lat_addr_r   <= {AW{1'b0}};
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= {AW{1'b0}};
            run_r        <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (flush_s) begin
                state_r     <= ST_IDLE;
                sdram_req_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (any_pending_s) begin
                            win_r        <= sel_s;
                            lat_addr_r   <= addr_s[sel_s];
                            sdram_addr_r <= req_addr_s;
                            sdram_req_r  <= 1'b1;
                            state_r      <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (sdram_ack) begin
                            sdram_req_r <= 1'b0;
                            state_r     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (data_rdy) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        sdram_req_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sdram_req  = sdram_req_r;
    assign sdram_addr = sdram_addr_r;
    // run_r keeps refresh low through reset and the first cycle after it
    assign refresh_en = run_r & ~flush_s & (state_r == ST_IDLE) & ~any_pending_s;

endmodule

// File: tb/tb_jtcontra_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_sdram_arb
// Directed self-checking bench for jtcontra_sdram_arb. Offsets are set so that
// each slot maps to a distinct SDRAM address and slot1 wraps past 2^22.
// -----------------------------------------------------------------------------
module tb_jtcontra_sdram_arb;

    logic        clk;
    logic        rst_n;
    logic        vblank, downloading, loop_rst;
    logic        slot0_cs, slot1_cs, slot2_cs, slot3_cs;
    logic [21:0] slot0_addr, slot1_addr, slot2_addr, slot3_addr;
    logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
    logic [31:0] slot0_dout, slot1_dout, slot2_dout, slot3_dout;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    int checks   = 0;
    int failures = 0;

    jtcontra_sdram_arb #(
        .SLOT0_OFFSET (22'h000010),
        .SLOT1_OFFSET (22'h3FFFFF),
        .SLOT2_OFFSET (22'h000200),
        .SLOT3_OFFSET (22'h000000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblank      (vblank),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot0_cs    (slot0_cs),
        .slot0_addr  (slot0_addr),
        .slot0_ok    (slot0_ok),
        .slot0_dout  (slot0_dout),
        .slot1_cs    (slot1_cs),
        .slot1_addr  (slot1_addr),
        .slot1_ok    (slot1_ok),
        .slot1_dout  (slot1_dout),
        .slot2_cs    (slot2_cs),
        .slot2_addr  (slot2_addr),
        .slot2_ok    (slot2_ok),
        .slot2_dout  (slot2_dout),
        .slot3_cs    (slot3_cs),
        .slot3_addr  (slot3_addr),
        .slot3_ok    (slot3_ok),
        .slot3_dout  (slot3_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answer a request already in REQ: one ack cycle then one data cycle
    task automatic serve(input logic [31:0] d);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic all_idle();
        slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0; slot3_cs = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vblank = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0; slot3_cs = 1'b1;
        slot0_addr = 22'h0; slot1_addr = 22'h0; slot2_addr = 22'h0; slot3_addr = 22'h123;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'h0;
        tick(); tick(); tick();
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rst_req act=%b exp=0", sdram_req); end
        checks++; if (sdram_addr !== 22'h0) begin failures++; $display("FAIL rst_addr act=%h exp=000000", sdram_addr); end
        checks++; if (refresh_en !== 1'b0) begin failures++; $display("FAIL rst_refresh act=%b exp=0", refresh_en); end
        checks++; if ({slot3_ok, slot2_ok, slot1_ok, slot0_ok} !== 4'b0000) begin failures++; $display("FAIL rst_ok act=%b exp=0000", {slot3_ok, slot2_ok, slot1_ok, slot0_ok}); end
        checks++; if ((slot0_dout | slot1_dout | slot2_dout | slot3_dout) !== 32'h0) begin failures++; $display("FAIL rst_dout act=%h exp=00000000", slot0_dout | slot1_dout | slot2_dout | slot3_dout); end
        slot3_cs = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL post_rst_refresh act=%b exp=1", refresh_en); end
    endtask

    task automatic test_cold_miss();
        slot3_cs = 1'b1; slot3_addr = 22'h00100;
        tick();
        checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL cold_req act=%b exp=1", sdram_req); end
        checks++; if (sdram_addr !== 22'h00100) begin failures++; $display("FAIL cold_addr act=%h exp=000100", sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL cold_req_fall act=%b exp=0", sdram_req); end
        data_rdy = 1'b1; data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        checks++; if (slot3_ok !== 1'b0) begin failures++; $display("FAIL cold_ok_early act=%b exp=0", slot3_ok); end
        tick();
        checks++; if (slot3_ok !== 1'b1) begin failures++; $display("FAIL cold_ok act=%b exp=1", slot3_ok); end
        checks++; if (slot3_dout !== 32'hDEADBEEF) begin failures++; $display("FAIL cold_dout act=%h exp=deadbeef", slot3_dout); end
    endtask

    task automatic test_hit();
        tick();
        checks++; if (slot3_ok !== 1'b1) begin failures++; $display("FAIL hit_ok act=%b exp=1", slot3_ok); end
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL hit_noreq act=%b exp=0", sdram_req); end
        checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL hit_refresh act=%b exp=1", refresh_en); end
        slot3_addr = 22'h00101;
        tick();
        checks++; if (slot3_ok !== 1'b0) begin failures++; $display("FAIL hit_change_ok act=%b exp=0", slot3_ok); end
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00101) begin failures++; $display("FAIL hit_refetch act=%b/%h exp=1/000101", sdram_req, sdram_addr); end
        serve(32'h11110101);
        tick();
        checks++; if (slot3_ok !== 1'b1 || slot3_dout !== 32'h11110101) begin failures++; $display("FAIL hit_refill act=%b/%h exp=1/11110101", slot3_ok, slot3_dout); end
    endtask

    task automatic test_priority();
        slot0_addr = 22'h10; slot1_addr = 22'h20; slot2_addr = 22'h30; slot3_addr = 22'h40;
        slot0_cs = 1'b1; slot1_cs = 1'b1; slot2_cs = 1'b1; slot3_cs = 1'b1;
        vblank = 1'b0;
        tick();
        checks++; if (sdram_addr !== 22'h000040) begin failures++; $display("FAIL prio_1st act=%h exp=000040", sdram_addr); end
        serve(32'hA3A3A3A3);
        tick();
        checks++; if (sdram_addr !== 22'h000230) begin failures++; $display("FAIL prio_2nd act=%h exp=000230", sdram_addr); end
        serve(32'hA2A2A2A2);
        tick();
        checks++; if (sdram_addr !== 22'h000020) begin failures++; $display("FAIL prio_3rd act=%h exp=000020", sdram_addr); end
        serve(32'hA0A0A0A0);
        tick();
        checks++; if (sdram_addr !== 22'h00001F) begin failures++; $display("FAIL prio_4th act=%h exp=00001f", sdram_addr); end
        serve(32'hA1A1A1A1);
        tick();
        checks++; if ({slot3_ok, slot2_ok, slot1_ok, slot0_ok} !== 4'b1111) begin failures++; $display("FAIL prio_ok act=%b exp=1111", {slot3_ok, slot2_ok, slot1_ok, slot0_ok}); end
        checks++; if (slot0_dout !== 32'hA0A0A0A0 || slot1_dout !== 32'hA1A1A1A1) begin failures++; $display("FAIL prio_dout01 act=%h/%h exp=a0a0a0a0/a1a1a1a1", slot0_dout, slot1_dout); end
        checks++; if (slot2_dout !== 32'hA2A2A2A2 || slot3_dout !== 32'hA3A3A3A3) begin failures++; $display("FAIL prio_dout23 act=%h/%h exp=a2a2a2a2/a3a3a3a3", slot2_dout, slot3_dout); end
        checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL prio_refresh act=%b exp=1", refresh_en); end
        all_idle();
    endtask

`ifdef JTCONTRA_ARB_VBLANK_RR_EN
    task automatic test_round_robin();
        slot0_addr = 22'h11; slot1_addr = 22'h21; slot2_addr = 22'h31; slot3_addr = 22'h41;
        slot0_cs = 1'b1; slot1_cs = 1'b1; slot2_cs = 1'b1; slot3_cs = 1'b1;
        vblank = 1'b0;
        tick();
        checks++; if (sdram_addr !== 22'h000041) begin failures++; $display("FAIL rr_1st act=%h exp=000041", sdram_addr); end
        vblank = 1'b1;
        serve(32'hB3B3B3B3);
        tick();
        checks++; if (sdram_addr !== 22'h000021) begin failures++; $display("FAIL rr_2nd act=%h exp=000021", sdram_addr); end
        serve(32'hB0B0B0B0);
        tick();
        checks++; if (sdram_addr !== 22'h000020) begin failures++; $display("FAIL rr_3rd act=%h exp=000020", sdram_addr); end
        serve(32'hB1B1B1B1);
        tick();
        checks++; if (sdram_addr !== 22'h000231) begin failures++; $display("FAIL rr_4th act=%h exp=000231", sdram_addr); end
        serve(32'hB2B2B2B2);
        vblank = 1'b0;
        all_idle();
    endtask
`endif

    task automatic test_offset_wrap();
        slot1_cs = 1'b1; slot1_addr = 22'h2;
        tick();
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000001) begin failures++; $display("FAIL wrap_addr act=%b/%h exp=1/000001", sdram_req, sdram_addr); end
        serve(32'h0000C0DE);
        tick();
        checks++; if (slot1_ok !== 1'b1 || slot1_dout !== 32'h0000C0DE) begin failures++; $display("FAIL wrap_fill act=%b/%h exp=1/0000c0de", slot1_ok, slot1_dout); end
        all_idle();
    endtask

    task automatic test_abort();
        slot3_cs = 1'b1; slot3_addr = 22'h90;
        tick();
        serve(32'h99999999);
        tick();
        checks++; if (slot3_ok !== 1'b1) begin failures++; $display("FAIL abort_pre_ok act=%b exp=1", slot3_ok); end
        slot2_cs = 1'b1; slot2_addr = 22'h50;
        tick();
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000250) begin failures++; $display("FAIL abort_req act=%b/%h exp=1/000250", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        downloading = 1'b1;
        tick();
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL abort_req_low act=%b exp=0", sdram_req); end
        checks++; if ({slot3_ok, slot2_ok, slot1_ok, slot0_ok} !== 4'b0000) begin failures++; $display("FAIL abort_ok act=%b exp=0000", {slot3_ok, slot2_ok, slot1_ok, slot0_ok}); end
        checks++; if (refresh_en !== 1'b0) begin failures++; $display("FAIL abort_refresh act=%b exp=0", refresh_en); end
        data_rdy = 1'b1; data_read = 32'hBADBAD00;
        tick();
        slot3_cs = 1'b0;
        downloading = 1'b0;
        tick();
        data_rdy = 1'b0;
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000250) begin failures++; $display("FAIL abort_remiss act=%b/%h exp=1/000250", sdram_req, sdram_addr); end
        checks++; if (slot2_ok !== 1'b0) begin failures++; $display("FAIL abort_nofill act=%b exp=0", slot2_ok); end
        serve(32'h22222222);
        tick();
        checks++; if (slot2_ok !== 1'b1 || slot2_dout !== 32'h22222222) begin failures++; $display("FAIL abort_refill act=%b/%h exp=1/22222222", slot2_ok, slot2_dout); end
    endtask

    task automatic test_mid_flight();
        slot2_cs = 1'b1; slot2_addr = 22'h60;
        tick();
        checks++; if (sdram_addr !== 22'h000260) begin failures++; $display("FAIL mid_req act=%h exp=000260", sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        slot2_addr = 22'h61;
        data_rdy = 1'b1; data_read = 32'h00006060;
        tick();
        data_rdy = 1'b0;
        checks++; if (slot2_ok !== 1'b0 || sdram_req !== 1'b0) begin failures++; $display("FAIL mid_gap act=%b/%b exp=0/0", slot2_ok, sdram_req); end
        slot2_addr = 22'h60;
        tick();
        checks++; if (slot2_ok !== 1'b1 || slot2_dout !== 32'h00006060 || sdram_req !== 1'b0) begin failures++; $display("FAIL mid_oldtag act=%b/%h/%b exp=1/00006060/0", slot2_ok, slot2_dout, sdram_req); end
        slot2_addr = 22'h61;
        tick();
        checks++; if (slot2_ok !== 1'b0 || sdram_req !== 1'b1 || sdram_addr !== 22'h000261) begin failures++; $display("FAIL mid_newreq act=%b/%b/%h exp=0/1/000261", slot2_ok, sdram_req, sdram_addr); end
        serve(32'h00006161);
        tick();
        checks++; if (slot2_ok !== 1'b1 || slot2_dout !== 32'h00006161) begin failures++; $display("FAIL mid_newfill act=%b/%h exp=1/00006161", slot2_ok, slot2_dout); end
        all_idle();
    endtask

    task automatic test_loop_rst();
        slot1_cs = 1'b1; slot1_addr = 22'h5;
        tick();
        checks++; if (sdram_addr !== 22'h000004) begin failures++; $display("FAIL loop_req act=%h exp=000004", sdram_addr); end
        loop_rst = 1'b1;
        tick();
        checks++; if (sdram_req !== 1'b0 || refresh_en !== 1'b0) begin failures++; $display("FAIL loop_hold act=%b/%b exp=0/0", sdram_req, refresh_en); end
        loop_rst = 1'b0;
        tick();
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000004) begin failures++; $display("FAIL loop_rearb act=%b/%h exp=1/000004", sdram_req, sdram_addr); end
        serve(32'h55555555);
        tick();
        checks++; if (slot1_ok !== 1'b1 || slot1_dout !== 32'h55555555) begin failures++; $display("FAIL loop_fill act=%b/%h exp=1/55555555", slot1_ok, slot1_dout); end
        all_idle();
    endtask

    task automatic test_reset_mid();
        slot0_cs = 1'b1; slot0_addr = 22'h70;
        tick();
        checks++; if (sdram_addr !== 22'h000080) begin failures++; $display("FAIL rmid_req act=%h exp=000080", sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rst_n = 1'b0;
        data_rdy = 1'b1; data_read = 32'h77777777;
        tick();
        data_rdy = 1'b0;
        checks++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin failures++; $display("FAIL rmid_hold act=%b/%h exp=0/000000", sdram_req, sdram_addr); end
        rst_n = 1'b1;
        tick();
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000080 || slot0_ok !== 1'b0) begin failures++; $display("FAIL rmid_remiss act=%b/%h/%b exp=1/000080/0", sdram_req, sdram_addr, slot0_ok); end
        serve(32'h70707070);
        tick();
        checks++; if (slot0_ok !== 1'b1 || slot0_dout !== 32'h70707070) begin failures++; $display("FAIL rmid_fill act=%b/%h exp=1/70707070", slot0_ok, slot0_dout); end
        all_idle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_priority();
`ifdef JTCONTRA_ARB_VBLANK_RR_EN
        test_round_robin();
`endif
        test_offset_wrap();
        test_abort();
        test_mid_flight();
        test_loop_rst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
